// File: rtl/icosoc_mod_spi_master.sv
// SPI mode-0 master on the icosoc ctrl bus: 8-bit MSB-first frames, programmable sclk divider.
// Data writes block (ctrl_done withheld) until the frame ends; CTRL/reads complete one cycle after acceptance.
module icosoc_mod_spi_master #(
  parameter logic [7:0] DEFAULT_DIV = 8'd10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [7:0]  ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done,
  output logic        cs,
  output logic        mosi,
  input  logic        miso,
  output logic        sclk
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic [2:0]  bit_q, bit_d;
  logic        cs_q, cs_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;
  logic [31:0] rdat_q, rdat_d;

  logic        busy;
  logic        accept;
  logic        phase_end;
  logic [7:0]  div_eff;
  logic        unused_wdat;

  assign busy        = (state_q != IDLE);
  // The host keeps its strobe up through the done cycle, so that edge must not re-accept.
  assign accept      = (ctrl_wr | ctrl_rd) & ~done_q & ~busy;
  assign div_eff     = (div_q == 8'd0) ? 8'd1 : div_q;
  assign phase_end   = (cnt_q == (div_eff - 8'd1));
  assign unused_wdat = ^ctrl_wdat[31:16];

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    rdat_d  = rdat_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ctrl_wr) begin
            case (ctrl_addr)
              8'h00: begin
                cs_d   = ctrl_wdat[0];
                div_d  = ctrl_wdat[15:8];
                done_d = 1'b1;
              end
              8'h04: begin
                shift_d = ctrl_wdat[7:0];
                mosi_d  = ctrl_wdat[7];
                bit_d   = 3'd0;
                cnt_d   = 8'd0;
                state_d = LOW;
              end
              default: done_d = 1'b1;
            endcase
          end else begin
            done_d = 1'b1;
            case (ctrl_addr)
              8'h00:   rdat_d = {16'b0, div_q, 6'b0, busy, cs_q};
              8'h04:   rdat_d = {24'b0, rx_q};
              default: rdat_d = 32'b0;
            endcase
          end
        end
      end
      LOW: begin
        if (phase_end) begin
          cnt_d   = 8'd0;
          sclk_d  = 1'b1;
          shift_d = {shift_q[6:0], miso};
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          cnt_d  = 8'd0;
          sclk_d = 1'b0;
          if (bit_q == 3'd7) begin
            rx_d    = shift_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            // After the rising-edge shift, bit 7 already holds the next bit to send.
            bit_d   = bit_q + 3'd1;
            mosi_d  = shift_q[7];
            state_d = LOW;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= IDLE;
      div_q   <= DEFAULT_DIV;
      cnt_q   <= 8'd0;
      shift_q <= 8'd0;
      rx_q    <= 8'd0;
      bit_q   <= 3'd0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      rdat_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      rdat_q  <= rdat_d;
    end
  end

  assign ctrl_rdat = rdat_q;
  assign ctrl_done = done_q;
  assign cs        = cs_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;

endmodule

// File: tb/tb_icosoc_mod_spi_master.sv
// Bench for icosoc_mod_spi_master: scoreboard of expected mosi bits / sclk rise times and read data.
module tb_icosoc_mod_spi_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ctrl_wr = 1'b0;
  logic        ctrl_rd = 1'b0;
  logic [7:0]  ctrl_addr = 8'h00;
  logic [31:0] ctrl_wdat = 32'h0;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;
  logic        cs, mosi, miso, sclk;

  localparam logic [7:0] SLV_TX = 8'h88;

  int miso_mode = 0;  // 0: loopback, 1: tied high, 2: slave model
  logic [2:0] slv_cnt = 3'd0;
  logic [7:0] slv_rx = 8'h00;
  logic       slv_miso;

  int cyc = 0;
  int e0 = 0;
  int n_cmp = 0;
  int n_bad = 0;

  int         exp_t_q[$];
  bit         exp_b_q[$];
  int         obs_t_q[$];
  bit         obs_b_q[$];
  logic [31:0] exp_rd_q[$];

  icosoc_mod_spi_master #(.DEFAULT_DIV(8'd10)) dut (
    .clk(clk), .resetn(resetn), .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd),
    .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat), .ctrl_rdat(ctrl_rdat),
    .ctrl_done(ctrl_done), .cs(cs), .mosi(mosi), .miso(miso), .sclk(sclk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign slv_miso = SLV_TX[3'd7 - slv_cnt];
  assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? 1'b1 : slv_miso;

  // Mode-0 slave: sample mosi on rising sclk, present the next tx bit after it.
  always @(posedge sclk or posedge cs) begin
    if (cs) slv_cnt <= 3'd0;
    else begin
      slv_rx  <= {slv_rx[6:0], mosi};
      slv_cnt <= slv_cnt + 3'd1;
    end
  end

  always @(posedge sclk) begin
    #1;
    obs_t_q.push_back(cyc - e0);
    obs_b_q.push_back(mosi);
  end

  task automatic push_frame(input logic [7:0] tx, input int div);
    for (int k = 0; k < 8; k++) begin
      exp_t_q.push_back((2 * k + 1) * div);
      exp_b_q.push_back(tx[7 - k]);
    end
  endtask

  task automatic bus_op(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                        input bit hold, output int lat, output logic [31:0] rd);
    ctrl_wr = wr; ctrl_rd = ~wr; ctrl_addr = addr; ctrl_wdat = wd;
    lat = -1; rd = 32'h0;
    @(posedge clk); #1;
    e0 = cyc;
    for (int i = 0; i < 5000; i++) begin
      if (ctrl_done) begin
        lat = i; rd = ctrl_rdat;
        break;
      end
      @(posedge clk); #1;
    end
    if (hold) begin
      @(posedge clk); #1;
    end
    ctrl_wr = 1'b0; ctrl_rd = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    int lat; logic [31:0] rd, exp;
    #3;
    n_cmp++;
    if ({cs, sclk, mosi, ctrl_done} !== 4'b1000 || ctrl_rdat !== 32'h0) begin
      n_bad++; $display("FAIL reset_outputs: got cs,sclk,mosi,done=%b rdat=%h, want 1000 rdat=0",
                        {cs, sclk, mosi, ctrl_done}, ctrl_rdat);
    end
    #9 resetn = 1'b0;
    @(posedge clk); #1;
    exp_rd_q.push_back(32'h00000A01);
    bus_op(1'b0, 8'h00, 32'h0, 1'b0, lat, rd);
    exp = exp_rd_q.pop_front();
    n_cmp++;
    if (rd !== exp || lat !== 0) begin
      n_bad++; $display("FAIL reset_ctrl_read: got %h lat %0d, want %h lat 0", rd, lat, exp);
    end
  endtask

  task automatic test_loopback_div1;
    int lat, et, ot; bit eb, ob; logic [31:0] rd, exp;
    miso_mode = 0;
    bus_op(1'b1, 8'h00, 32'h00000100, 1'b0, lat, rd);
    n_cmp++;
    if (cs !== 1'b0 || lat !== 0) begin
      n_bad++; $display("FAIL ctrl_write: got cs=%b lat %0d, want cs=0 lat 0", cs, lat);
    end
    push_frame(8'hA5, 1);
    bus_op(1'b1, 8'h04, 32'h000000A5, 1'b0, lat, rd);
    n_cmp++;
    if (lat !== 16) begin
      n_bad++; $display("FAIL a5_frame_len: got %0d, want 16", lat);
    end
    while (exp_t_q.size() > 0) begin
      et = exp_t_q.pop_front(); eb = exp_b_q.pop_front(); n_cmp++;
      if (obs_t_q.size() == 0) begin
        n_bad++; $display("FAIL a5_edge: got no edge, want edge at %0d", et);
      end else begin
        ot = obs_t_q.pop_front(); ob = obs_b_q.pop_front();
        if (ot !== et || ob !== eb) begin
          n_bad++; $display("FAIL a5_edge: got t=%0d mosi=%b, want t=%0d mosi=%b", ot, ob, et, eb);
        end
      end
    end
    exp_rd_q.push_back(32'h000000A5);
    bus_op(1'b0, 8'h04, 32'h0, 1'b0, lat, rd);
    exp = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== exp) begin
      n_bad++; $display("FAIL a5_rx: got %h, want %h", rd, exp);
    end
  endtask

  task automatic test_div10_miso1;
    int lat, et, ot; bit eb, ob; logic [31:0] rd, exp;
    miso_mode = 1;
    bus_op(1'b1, 8'h00, 32'h00000A00, 1'b0, lat, rd);
    push_frame(8'h55, 10);
    bus_op(1'b1, 8'h04, 32'h00000055, 1'b0, lat, rd);
    n_cmp++;
    if (lat !== 160) begin
      n_bad++; $display("FAIL div10_frame_len: got %0d, want 160", lat);
    end
    while (exp_t_q.size() > 0) begin
      et = exp_t_q.pop_front(); eb = exp_b_q.pop_front(); n_cmp++;
      if (obs_t_q.size() == 0) begin
        n_bad++; $display("FAIL div10_edge: got no edge, want edge at %0d", et);
      end else begin
        ot = obs_t_q.pop_front(); ob = obs_b_q.pop_front();
        if (ot !== et || ob !== eb) begin
          n_bad++; $display("FAIL div10_edge: got t=%0d mosi=%b, want t=%0d mosi=%b", ot, ob, et, eb);
        end
      end
    end
    exp_rd_q.push_back(32'h000000FF);
    exp_rd_q.push_back(32'h00000A00);
    bus_op(1'b0, 8'h04, 32'h0, 1'b0, lat, rd);
    exp = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== exp) begin
      n_bad++; $display("FAIL div10_rx: got %h, want %h", rd, exp);
    end
    bus_op(1'b0, 8'h00, 32'h0, 1'b0, lat, rd);
    exp = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== exp) begin
      n_bad++; $display("FAIL div10_ctrl_busy: got %h, want %h", rd, exp);
    end
  endtask

  task automatic test_slave_pair;
    int lat, et, ot; bit eb, ob; logic [31:0] rd, exp;
    miso_mode = 2;
    bus_op(1'b1, 8'h00, 32'h00000201, 1'b0, lat, rd);
    bus_op(1'b1, 8'h00, 32'h00000200, 1'b0, lat, rd);
    push_frame(8'h55, 2);
    bus_op(1'b1, 8'h04, 32'h00000055, 1'b0, lat, rd);
    n_cmp++;
    if (lat !== 32) begin
      n_bad++; $display("FAIL slave_frame_len: got %0d, want 32", lat);
    end
    while (exp_t_q.size() > 0) begin
      et = exp_t_q.pop_front(); eb = exp_b_q.pop_front(); n_cmp++;
      if (obs_t_q.size() == 0) begin
        n_bad++; $display("FAIL slave_edge: got no edge, want edge at %0d", et);
      end else begin
        ot = obs_t_q.pop_front(); ob = obs_b_q.pop_front();
        if (ot !== et || ob !== eb) begin
          n_bad++; $display("FAIL slave_edge: got t=%0d mosi=%b, want t=%0d mosi=%b", ot, ob, et, eb);
        end
      end
    end
    exp_rd_q.push_back({24'h0, SLV_TX});
    bus_op(1'b0, 8'h04, 32'h0, 1'b0, lat, rd);
    exp = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== exp) begin
      n_bad++; $display("FAIL slave_master_rx: got %h, want %h", rd, exp);
    end
    n_cmp++;
    if (slv_rx !== 8'h55) begin
      n_bad++; $display("FAIL slave_rx: got %h, want 55", slv_rx);
    end
  endtask

  task automatic test_reset_midframe;
    int lat; logic [31:0] rd, exp; bit saw_done;
    miso_mode = 0;
    bus_op(1'b1, 8'h00, 32'h00000200, 1'b0, lat, rd);
    ctrl_wr = 1'b1; ctrl_addr = 8'h04; ctrl_wdat = 32'h000000E0;
    @(posedge clk); #1;
    e0 = cyc;
    repeat (11) @(posedge clk);
    #1;
    n_cmp++;
    if (sclk !== 1'b1 || mosi !== 1'b1) begin
      n_bad++; $display("FAIL midframe_pre: got sclk=%b mosi=%b, want 1 1", sclk, mosi);
    end
    resetn = 1'b1;
    #1;
    n_cmp++;
    if ({cs, sclk, mosi, ctrl_done} !== 4'b1000) begin
      n_bad++; $display("FAIL midframe_reset: got cs,sclk,mosi,done=%b, want 1000", {cs, sclk, mosi, ctrl_done});
    end
    ctrl_wr = 1'b0;
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ctrl_done) saw_done = 1'b1;
    end
    resetn = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ctrl_done) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0 || obs_t_q.size() != 3) begin
      n_bad++; $display("FAIL midframe_abort: got done_seen=%b edges=%0d, want 0 and 3", saw_done, obs_t_q.size());
    end
    obs_t_q.delete(); obs_b_q.delete();
    exp_rd_q.push_back(32'h00000A01);
    exp_rd_q.push_back(32'h00000000);
    bus_op(1'b0, 8'h00, 32'h0, 1'b0, lat, rd);
    exp = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== exp) begin
      n_bad++; $display("FAIL midframe_ctrl: got %h, want %h", rd, exp);
    end
    bus_op(1'b0, 8'h04, 32'h0, 1'b0, lat, rd);
    exp = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== exp) begin
      n_bad++; $display("FAIL midframe_rx: got %h, want %h", rd, exp);
    end
  endtask

  task automatic test_div0_unmapped;
    int lat, et, ot; bit eb, ob; logic [31:0] rd, exp;
    miso_mode = 0;
    bus_op(1'b1, 8'h00, 32'h00000000, 1'b0, lat, rd);
    push_frame(8'h3C, 1);
    bus_op(1'b1, 8'h04, 32'h0000003C, 1'b0, lat, rd);
    n_cmp++;
    if (lat !== 16) begin
      n_bad++; $display("FAIL div0_frame_len: got %0d, want 16", lat);
    end
    while (exp_t_q.size() > 0) begin
      et = exp_t_q.pop_front(); eb = exp_b_q.pop_front(); n_cmp++;
      if (obs_t_q.size() == 0) begin
        n_bad++; $display("FAIL div0_edge: got no edge, want edge at %0d", et);
      end else begin
        ot = obs_t_q.pop_front(); ob = obs_b_q.pop_front();
        if (ot !== et || ob !== eb) begin
          n_bad++; $display("FAIL div0_edge: got t=%0d mosi=%b, want t=%0d mosi=%b", ot, ob, et, eb);
        end
      end
    end
    bus_op(1'b1, 8'h08, 32'hFFFFFFFF, 1'b0, lat, rd);
    n_cmp++;
    if (lat !== 0 || cs !== 1'b0) begin
      n_bad++; $display("FAIL unmapped_write: got lat %0d cs=%b, want lat 0 cs=0", lat, cs);
    end
    exp_rd_q.push_back(32'h00000000);
    exp_rd_q.push_back(32'h00000000);
    exp_rd_q.push_back(32'h0000003C);
    bus_op(1'b0, 8'h08, 32'h0, 1'b0, lat, rd);
    exp = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== exp || lat !== 0) begin
      n_bad++; $display("FAIL unmapped_read: got %h lat %0d, want %h lat 0", rd, lat, exp);
    end
    bus_op(1'b0, 8'h00, 32'h0, 1'b0, lat, rd);
    exp = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== exp) begin
      n_bad++; $display("FAIL unmapped_ctrl_kept: got %h, want %h", rd, exp);
    end
    bus_op(1'b0, 8'h04, 32'h0, 1'b0, lat, rd);
    exp = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== exp) begin
      n_bad++; $display("FAIL div0_rx: got %h, want %h", rd, exp);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] rd, exp;
    miso_mode = 0;
    bus_op(1'b1, 8'h00, 32'h00000100, 1'b0, lat, rd);
    bus_op(1'b1, 8'h04, 32'h00000081, 1'b1, lat, rd);
    n_cmp++;
    if (lat !== 16 || obs_t_q.size() != 8) begin
      n_bad++; $display("FAIL held_frame: got lat %0d edges %0d, want 16 and 8", lat, obs_t_q.size());
    end
    obs_t_q.delete(); obs_b_q.delete();
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_t_q.size() != 0 || sclk !== 1'b0) begin
      n_bad++; $display("FAIL held_no_second: got edges %0d sclk=%b, want 0 and 0", obs_t_q.size(), sclk);
    end
    exp_rd_q.push_back(32'h00000100);
    exp_rd_q.push_back(32'h00000081);
    bus_op(1'b0, 8'h00, 32'h0, 1'b0, lat, rd);
    exp = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== exp) begin
      n_bad++; $display("FAIL held_ctrl: got %h, want %h", rd, exp);
    end
    bus_op(1'b0, 8'h04, 32'h0, 1'b0, lat, rd);
    exp = exp_rd_q.pop_front(); n_cmp++;
    if (rd !== exp) begin
      n_bad++; $display("FAIL held_rx: got %h, want %h", rd, exp);
    end
  endtask

  initial begin
    #2 resetn = 1'b1;
    test_reset();
    test_loopback_div1();
    test_div10_miso1();
    test_slave_pair();
    test_reset_midframe();
    test_div0_unmapped();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icosoc_mod_spi_master.md
# icosoc_mod_spi_master

SPI bus master peripheral (mode 0, MSB first, 8-bit frames) sitting on the icosoc ctrl bus, the initiating counterpart of the SPI slave core. Software programs a clock divider and drives chip-select via a control register, then writes a byte to the data register to shift it out on mosi while capturing miso. The data write is blocking: ctrl_done is withheld until the frame is finished, and the received byte is then readable.

## Interface
- DEFAULT_DIV, 10, reset value of the sclk half-period divider in clk cycles (8-bit).

- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  reset, asynchronous, active-high (named resetn; asserted = 1).
- ctrl_wr  in  1  write request, held until ctrl_done.
- ctrl_rd  in  1  read request, held until ctrl_done.
- ctrl_addr  in  8  register address.
- ctrl_wdat  in  32  write data.
- ctrl_rdat  out  32  read data, registered.
- ctrl_done  out  1  one-cycle completion pulse.
- cs  out  1  chip select to slave, active-low, software controlled.
- mosi  out  1  serial data to slave.
- miso  in  1  serial data from slave.
- sclk  out  1  serial clock, idle low.

## Operation
- Registers:
  - 0x00 CTRL write: cs <= wdat[0]; div <= wdat[15:8]. Read: {16'b0, div, 6'b0, busy, cs}.
  - 0x04 DATA write: starts a frame with tx = wdat[7:0]. Read: {24'b0, rx}.
  - Any other address: read returns 0, write ignored; both complete normally.
- A request is accepted on an edge where (ctrl_wr | ctrl_rd) = 1 and ctrl_done = 0; the edge on which ctrl_done is high never accepts (host drops strobe after seeing done). ctrl_wr has priority if both high.
- div = 0 behaves as div = 1.
- FSM: IDLE, LOW, HIGH.
  - IDLE: sclk=0, busy=0. DATA write accepted -> load shift register with tx, mosi <= tx[7], bit count 0, phase counter 0, -> LOW, busy=1.
  - LOW: sclk=0; after div cycles -> HIGH, sclk <= 1, sample miso into shift LSB side.
  - HIGH: sclk=1; after div cycles sclk <= 0; if bit count = 7 -> IDLE, rx <= assembled byte, ctrl_done pulse; else bit count +1, mosi <= next bit, -> LOW.
- cs is never changed by the FSM; software frames transfers. cs is driven regardless of busy.
- Only one request in flight; during a frame the bus is held by the blocking write, so no other request arrives.
- Reads/CTRL writes: ctrl_done pulses one cycle after acceptance; ctrl_rdat updated at acceptance edge of reads and held until the next read.

## Timing
- Reset values: cs=1, sclk=0, mosi=0, ctrl_done=0, ctrl_rdat=0, div=DEFAULT_DIV, rx=0, busy=0, state IDLE.
- Reset asserted mid-frame: all of the above immediately (asynchronous), frame aborted, no ctrl_done, rx unchanged from reset value 0.
- DATA write accepted at edge E0: mosi valid from E0; sclk rising edges at E0+(2k+1)*div, falling at E0+(2k+2)*div, k=0..7; mosi changes only at falling edges; ctrl_done high for the cycle after edge E0+16*div; rx valid from that same edge.
- Frame length = 16*div clk cycles; div=1 gives 16 cycles.
- Register access latency: ctrl_done one cycle after acceptance, ctrl_rdat valid while ctrl_done high.

## Test plan
- After reset: cs=1, sclk=0, mosi=0; read 0x00 -> 0x00000A01, done one cycle after acceptance.
- Write 0x00=0x00000100 (div 1, cs 0), miso looped from mosi, write 0x04=0xA5 -> mosi 1,0,1,0,0,1,0,1 on 8 rising sclk edges, done 16 cycles after acceptance; read 0x04 -> 0x000000A5.
- div=10, miso tied 1, write 0x04=0x55 -> sclk edges every 10 cycles, done at 160 cycles; read 0x04 -> 0x000000FF; read 0x00 -> busy=0.
- Pair with the team's SPI slave core (slave preloaded 0x88), cs=0, master writes 0x55 -> master reads 0x04 = 0x88, slave data register = 0x55.
- Assert resetn after 3 bits of a div=2 frame -> cs=1, sclk=0, mosi=0, no ctrl_done, read 0x00 -> 0x00000A01.
- div=0 frame completes in 16 cycles; read 0x08 -> 0, write 0x08 -> no state change; wr held one cycle past done -> no second frame.
